filter_frac_2d: RTL and testbench

Pipelined, parametrised separable 2-tap (bilinear) fractional-pel interpolator for motion compensation. It is the successor to the combinational quarter-pel row filter and adds the following:
- any fractional phase in both X and Y
- a vertical pass using a one-row line register
- valid/ready streaming with back-pressure
- configurable pixel count and bit depth

It sits between the reference-pixel fetch and the prediction buffer.

---
 rtl/filter_pkg.sv | 17 +
 rtl/filter_tap2.sv | 26 ++
 rtl/filter_frac_2d.sv | 120 ++++++++++++
 tb/tb_filter_frac_2d.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared constants for the fractional-pel interpolator.
// FILTER_FRAC_EIGHTH_EN selects eighth-pel phases (chroma); quarter-pel otherwise.
package filter_pkg;

`ifdef FILTER_FRAC_EIGHTH_EN
    localparam int FRAC_W = 3;
`else
    localparam int FRAC_W = 2;
`endif

    localparam int FRAC_ONE   = 1 << FRAC_W;
    localparam int FRAC_SHIFT = 2 * FRAC_W;
    localparam int FRAC_RND   = (FRAC_ONE * FRAC_ONE) / 2;

    typedef logic [FRAC_W-1:0] frac_t;

endpackage

// File: rtl/filter_tap2.sv
// Weighted 2-tap sum: (W-frac)*a + frac*b with W = 1<<FRAC_W, unrounded.
module filter_tap2 #(
    parameter int IN_W   = 8,
    parameter int FRAC_W = 2
) (
    input  logic [IN_W-1:0]        a,
    input  logic [IN_W-1:0]        b,
    input  logic [FRAC_W-1:0]      frac,
    output logic [IN_W+FRAC_W-1:0] sum
);

    localparam int OUT_W = IN_W + FRAC_W;

    logic [FRAC_W:0]  wa;
    logic [OUT_W-1:0] pa;
    logic [OUT_W-1:0] pb;

    // The weights always add up to W, so the sum never exceeds W*max(a,b) and fits OUT_W.
    always_comb begin
        wa  = (FRAC_W+1)'(1 << FRAC_W) - {1'b0, frac};
        pa  = OUT_W'(a) * OUT_W'(wa);
        pb  = OUT_W'(b) * OUT_W'(frac);
        sum = pa + pb;
    end

endmodule

// File: rtl/filter_frac_2d.sv
// Pipelined separable bilinear fractional-pel interpolator with a one-row line register.
// Phase width comes from filter_pkg (FILTER_FRAC_EIGHTH_EN selects eighth-pel).
module filter_frac_2d
    import filter_pkg::*;
#(
    parameter int N_PIX     = 8,
    parameter int BIT_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_PIX*BIT_DEPTH-1:0]     in_pix,
    input  logic                           in_first,
    input  logic                           in_last,
    input  logic [FRAC_W-1:0]              in_frac_x,
    input  logic [FRAC_W-1:0]              in_frac_y,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [(N_PIX-1)*BIT_DEPTH-1:0] out_pix,
    output logic                           out_last
);

    localparam int N_OUT = N_PIX - 1;
    localparam int H_W   = BIT_DEPTH + FRAC_W;
    localparam int V_W   = BIT_DEPTH + 2 * FRAC_W;
    localparam int ACC_W = V_W + 1;

    logic                        enable;
    logic                        produce;
    frac_t                       fx_q;
    frac_t                       fy_q;
    frac_t                       fx_eff;
    frac_t                       s1_fy;
    logic                        s1_valid;
    logic                        s1_first;
    logic                        s1_last;
    logic                        line_valid;
    logic [N_OUT-1:0][H_W-1:0]   h_comb;
    logic [N_OUT-1:0][H_W-1:0]   s1_h;
    logic [N_OUT-1:0][H_W-1:0]   line_h;
    logic [N_OUT-1:0][V_W-1:0]   v_sum;
    logic [N_OUT*BIT_DEPTH-1:0]  v_pix;

    assign enable   = !out_valid || out_ready;
    assign in_ready = enable;
    assign fx_eff   = in_first ? in_frac_x : fx_q;
    assign produce  = !s1_first && line_valid;

    for (genvar k = 0; k < N_OUT; k++) begin : g_tap
        logic [ACC_W-1:0] acc;

        filter_tap2 #(.IN_W(BIT_DEPTH), .FRAC_W(FRAC_W)) u_h (
            .a    (in_pix[k*BIT_DEPTH +: BIT_DEPTH]),
            .b    (in_pix[(k+1)*BIT_DEPTH +: BIT_DEPTH]),
            .frac (fx_eff),
            .sum  (h_comb[k])
        );

        filter_tap2 #(.IN_W(H_W), .FRAC_W(FRAC_W)) u_v (
            .a    (line_h[k]),
            .b    (s1_h[k]),
            .frac (s1_fy),
            .sum  (v_sum[k])
        );

        // Rounded result always fits BIT_DEPTH, so plain truncation after the shift is safe.
        assign acc = {1'b0, v_sum[k]} + ACC_W'(FRAC_RND);
        assign v_pix[k*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'(acc >> FRAC_SHIFT);
    end

    // Stage 1: horizontal result; fy travels with the row so a restart cannot skew older rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fx_q     <= '0;
            fy_q     <= '0;
            s1_fy    <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_h     <= '0;
        end else if (enable) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_h     <= h_comb;
                s1_first <= in_first;
                s1_last  <= in_last;
                s1_fy    <= in_first ? in_frac_y : fy_q;
                if (in_first) begin
                    fx_q <= in_frac_x;
                    fy_q <= in_frac_y;
                end
            end
        end
    end

    // Stage 2: vertical result, then the current row becomes the previous row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pix    <= '0;
            out_last   <= 1'b0;
            line_h     <= '0;
            line_valid <= 1'b0;
        end else if (enable) begin
            if (s1_valid) begin
                out_valid  <= produce;
                if (produce) begin
                    out_pix  <= v_pix;
                    out_last <= s1_last;
                end
                line_h     <= s1_h;
                line_valid <= !s1_last;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_frac_2d.sv
// Directed self-checking bench for filter_frac_2d; expectations follow FILTER_FRAC_EIGHTH_EN.
`timescale 1ns/1ps
module tb_filter_frac_2d;
    import filter_pkg::*;

    localparam int N_PIX     = 8;
    localparam int BIT_DEPTH = 8;
    localparam int IN_W      = N_PIX * BIT_DEPTH;
    localparam int OUT_W     = (N_PIX - 1) * BIT_DEPTH;

    typedef struct {
        frac_t            fx;
        frac_t            fy;
        logic [IN_W-1:0]  row0;
        logic [IN_W-1:0]  row1;
        logic [OUT_W-1:0] exp_pix;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_pix;
    logic              in_first;
    logic              in_last;
    logic [FRAC_W-1:0] in_frac_x;
    logic [FRAC_W-1:0] in_frac_y;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_pix;
    logic              out_last;

    int               checks   = 0;
    int               failures = 0;
    logic [OUT_W-1:0] got_pix[$];
    logic             got_last[$];
    vec_t             vecs[4];
    logic [OUT_W-1:0] held;
    logic [OUT_W-1:0] exp_c;
    logic [OUT_W-1:0] exp_d;

    always #5 clk = ~clk;

    filter_frac_2d #(.N_PIX(N_PIX), .BIT_DEPTH(BIT_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_frac_x (in_frac_x),
        .in_frac_y (in_frac_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_last  (out_last)
    );

    function automatic logic [IN_W-1:0] make_row(input int base, input int step);
        logic [IN_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_PIX; k++) r[k*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'(base + step * k);
        return r;
    endfunction

    function automatic vec_t make_vec(input int fx, input int fy, input logic [IN_W-1:0] r0,
                                      input logic [IN_W-1:0] r1, input logic [OUT_W-1:0] e);
        vec_t v;
        v.fx = frac_t'(fx);
        v.fy = frac_t'(fy);
        v.row0 = r0;
        v.row1 = r1;
        v.exp_pix = e;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [IN_W-1:0] pix, input logic first, input logic last,
                                  input int fx, input int fy);
        int budget;
        budget = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_pix    = pix;
        in_first  = first;
        in_last   = last;
        in_frac_x = frac_t'(fx);
        in_frac_y = frac_t'(fy);
        #1;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!in_ready) check_output("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Records every accepted output row, sampled between the drive point and the next active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready && !rst) begin
                got_pix.push_back(out_pix);
                got_last.push_back(out_last);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pix = '0; in_first = 1'b0; in_last = 1'b0;
        in_frac_x = '0; in_frac_y = '0; out_ready = 1'b1;

        vecs[0] = make_vec(0, 0, make_row(0, 10), make_row(5, 10), OUT_W'(make_row(0, 10)));
`ifdef FILTER_FRAC_EIGHTH_EN
        vecs[1] = make_vec(1, 0, 64'h0000_0000_0000_0800, '0, 56'h00_0000_0000_0701);
        vecs[2] = make_vec(4, 4, make_row(100, 0), make_row(200, 0), OUT_W'(make_row(150, 0)));
        exp_c = OUT_W'(make_row(2, 4));
        exp_d = OUT_W'(make_row(3, 8));
`else
        vecs[1] = make_vec(1, 0, 64'h0000_0000_0000_FF00, '0, 56'h00_0000_0000_BF40);
        vecs[2] = make_vec(2, 2, make_row(100, 0), make_row(200, 0), OUT_W'(make_row(150, 0)));
        exp_c = OUT_W'(make_row(3, 4));
        exp_d = OUT_W'(make_row(6, 8));
`endif
        vecs[3] = make_vec(3, 3, make_row(255, 0), make_row(255, 0), OUT_W'(make_row(255, 0)));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_out_pix", 64'(out_pix), 64'd0);
        check_output("reset_out_last", 64'(out_last), 64'd0);
        check_output("reset_in_ready", 64'(in_ready), 64'd1);

        // Two-row blocks: first row is silent, output lands two edges after the second row.
        for (int i = 0; i < 4; i++) begin
            got_pix.delete(); got_last.delete();
            apply_stimulus(vecs[i].row0, 1'b1, 1'b0, int'(vecs[i].fx), int'(vecs[i].fy));
            apply_stimulus(vecs[i].row1, 1'b0, 1'b1, 0, 0);
            @(negedge clk); #1;
            check_output($sformatf("vec%0d_no_early_valid", i), 64'(out_valid), 64'd0);
            @(negedge clk); #1;
            check_output($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check_output($sformatf("vec%0d_pix", i), 64'(out_pix), 64'(vecs[i].exp_pix));
            check_output($sformatf("vec%0d_last", i), 64'(out_last), 64'd1);
            repeat (2) @(negedge clk);
            check_output($sformatf("vec%0d_count", i), 64'(got_pix.size()), 64'd1);
        end

        // Back-pressure: 5-row block with a 3-cycle output stall.
        got_pix.delete(); got_last.delete();
        fork
            begin
                for (int r = 0; r < 5; r++) apply_stimulus(make_row(16 * r, 1), r == 0, r == 4, 0, 0);
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    #2;
                    check_output("bp_out_valid", 64'(out_valid), 64'd1);
                    check_output("bp_in_ready", 64'(in_ready), 64'd0);
                    if (j == 0) held = out_pix;
                    else check_output("bp_hold_pix", 64'(out_pix), 64'(held));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        check_output("bp_count", 64'(got_pix.size()), 64'd4);
        for (int r = 0; r < 4; r++) begin
            if (r < got_pix.size()) begin
                check_output($sformatf("bp_row%0d_pix", r), 64'(got_pix[r]), 64'(OUT_W'(make_row(16 * r, 1))));
                check_output($sformatf("bp_row%0d_last", r), 64'(got_last[r]), 64'(r == 3));
            end
        end

        // Mid-block restart with new fx=3.
        got_pix.delete(); got_last.delete();
        apply_stimulus(make_row(1, 1), 1'b1, 1'b0, 0, 0);
        apply_stimulus(make_row(50, 2), 1'b0, 1'b0, 0, 0);
        apply_stimulus(make_row(0, 4), 1'b1, 1'b0, 3, 0);
        apply_stimulus(make_row(0, 8), 1'b0, 1'b0, 1, 1);
        apply_stimulus(make_row(0, 0), 1'b0, 1'b1, 2, 2);
        repeat (5) @(negedge clk);
        check_output("restart_count", 64'(got_pix.size()), 64'd3);
        if (got_pix.size() == 3) begin
            check_output("restart_row0_pix", 64'(got_pix[0]), 64'(OUT_W'(make_row(1, 1))));
            check_output("restart_row1_pix", 64'(got_pix[1]), 64'(exp_c));
            check_output("restart_row2_pix", 64'(got_pix[2]), 64'(exp_d));
            check_output("restart_row0_last", 64'(got_last[0]), 64'd0);
            check_output("restart_row2_last", 64'(got_last[2]), 64'd1);
        end

        // Reset with rows in flight, then a non-first row must still only prime the line.
        got_pix.delete(); got_last.delete();
        apply_stimulus(make_row(9, 1), 1'b1, 1'b0, 0, 0);
        apply_stimulus(make_row(20, 1), 1'b0, 1'b0, 0, 0);
        apply_stimulus(make_row(30, 1), 1'b0, 1'b0, 0, 0);
        check_output("rst_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        got_pix.delete(); got_last.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_output("rst_no_stale", 64'(got_pix.size()), 64'd0);
        check_output("rst_idle_valid", 64'(out_valid), 64'd0);
        apply_stimulus(make_row(40, 1), 1'b0, 1'b0, 0, 0);
        apply_stimulus(make_row(70, 1), 1'b0, 1'b1, 0, 0);
        repeat (5) @(negedge clk);
        check_output("post_rst_count", 64'(got_pix.size()), 64'd1);
        if (got_pix.size() == 1) begin
            check_output("post_rst_pix", 64'(got_pix[0]), 64'(OUT_W'(make_row(40, 1))));
            check_output("post_rst_last", 64'(got_last[0]), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
